// File: rtl/sdram_model_pkg.sv
// Shared definitions for the parametrised SDR SDRAM behavioural model:
// command encodings, mode-register field decoders and pipeline depth.
package sdram_model_pkg;

    localparam int CL_MAX = 3;

    typedef enum logic [2:0] {
        CMD_LOAD_MODE = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BST       = 3'b110,
        CMD_NOP       = 3'b111
    } cmd_e;

    function automatic logic [3:0] bl_decode(input logic [2:0] code);
        case (code)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [1:0] cl_decode(input logic [2:0] code);
        return (code == 3'd2) ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Read-data return path: CAS-latency delay line of data+valid and the
// two-stage DQM delay that produces per-bit dq drive enables.
module sdram_rd_pipe
    import sdram_model_pkg::*;
#(
    parameter int DQ_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                flush,
    input  logic [1:0]          cl,
    input  logic                in_valid,
    input  logic [DQ_W-1:0]     in_data,
    input  logic [DQ_W/8-1:0]   dqm,
    output logic [DQ_W-1:0]     dq_oe,
    output logic [DQ_W-1:0]     dq_out
);

    localparam int NBYTE = DQ_W / 8;

    logic [CL_MAX-1:0] valid_q, valid_d;
    logic [DQ_W-1:0]   data_q [CL_MAX];
    logic [DQ_W-1:0]   data_d [CL_MAX];
    logic [NBYTE-1:0]  dqm_q  [2];
    logic [NBYTE-1:0]  dqm_d  [2];
    logic [1:0]        tap;
    logic              out_valid;

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        dqm_d   = dqm_q;
        if (en) begin
            valid_d   = {valid_q[CL_MAX-2:0], in_valid};
            data_d[0] = in_data;
            for (int i = 1; i < CL_MAX; i++) begin
                data_d[i] = data_q[i-1];
            end
            dqm_d[0] = dqm;
            dqm_d[1] = dqm_q[0];
            if (flush) begin
                valid_d = '0;
            end
        end
    end

    // NOTE: non-blocking assignments so each flop samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
            dqm_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            dqm_q   <= dqm_d;
        end
    end

    // Stage 0 holds the word fetched at the command edge; CL2 drives stage 1, CL3 stage 2.
    always_comb begin
        tap       = (cl == 2'd3) ? 2'd2 : 2'd1;
        out_valid = valid_q[tap];
        dq_out    = data_q[tap];
        for (int b = 0; b < DQ_W; b++) begin
            dq_oe[b] = out_valid & ~dqm_q[1][b/8];
        end
    end

endmodule

// File: rtl/sdram_model_param.sv
// Parametrised cycle-accurate SDR SDRAM chip model: command decode, per-bank
// open rows, sequential bursts with auto-precharge, and a sticky error flag.
module sdram_model_param
    import sdram_model_pkg::*;
#(
    parameter int DQ_W   = 16,
    parameter int BANK_W = 2,
    parameter int ROW_W  = 13,
    parameter int COL_W  = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cke,
    input  logic                cs,
    input  logic                ras,
    input  logic                cas,
    input  logic                we,
    input  logic [ROW_W-1:0]    a,
    input  logic [BANK_W-1:0]   ba,
    input  logic [DQ_W/8-1:0]   dqm,
    inout  wire  [DQ_W-1:0]     dq,
    output logic                err
);

    localparam int NBANK = 1 << BANK_W;
    localparam int NBYTE = DQ_W / 8;
    localparam int AW    = BANK_W + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    logic [3:0]        bl_q, bl_d;
    logic [1:0]        cl_q, cl_d;
    logic              wr_single_q, wr_single_d;
    logic [NBANK-1:0]  open_q, open_d;
    logic [ROW_W-1:0]  row_q [NBANK];
    logic [ROW_W-1:0]  row_d [NBANK];
    logic              burst_q, burst_d;
    logic              burst_wr_q, burst_wr_d;
    logic [BANK_W-1:0] burst_bank_q, burst_bank_d;
    logic [ROW_W-1:0]  burst_row_q, burst_row_d;
    logic [COL_W-1:0]  burst_col_q, burst_col_d;
    logic [2:0]        burst_cnt_q, burst_cnt_d;
    logic [2:0]        burst_mask_q, burst_mask_d;
    logic              burst_ap_q, burst_ap_d;
    logic              err_q, err_d;

    cmd_e              cmd;
    logic              rw_ok;
    logic [2:0]        new_mask;
    logic              beat_en, beat_wr, flush;
    logic [BANK_W-1:0] beat_bank;
    logic [ROW_W-1:0]  beat_row;
    logic [COL_W-1:0]  beat_col;
    logic [AW-1:0]     beat_addr;
    logic [DQ_W-1:0]   rd_word;
    logic [DQ_W-1:0]   dq_oe, dq_out;
    logic [DQ_W-1:0]   mem_q [DEPTH];

    // Sequential wrap: low bits selected by mask count modulo BL, upper bits fixed.
    function automatic logic [COL_W-1:0] burst_column(input logic [COL_W-1:0] start,
                                                      input logic [2:0] k,
                                                      input logic [2:0] mask);
        logic [COL_W-1:0] m;
        m = COL_W'(mask);
        return (start & ~m) | ((start + COL_W'(k)) & m);
    endfunction

    always_comb begin
        cmd = cs ? CMD_NOP : cmd_e'({ras, cas, we});
    end

    always_comb begin
        bl_d         = bl_q;
        cl_d         = cl_q;
        wr_single_d  = wr_single_q;
        open_d       = open_q;
        row_d        = row_q;
        burst_d      = burst_q;
        burst_wr_d   = burst_wr_q;
        burst_bank_d = burst_bank_q;
        burst_row_d  = burst_row_q;
        burst_col_d  = burst_col_q;
        burst_cnt_d  = burst_cnt_q;
        burst_mask_d = burst_mask_q;
        burst_ap_d   = burst_ap_q;
        err_d        = err_q;
        beat_en      = 1'b0;
        beat_wr      = 1'b0;
        beat_bank    = burst_bank_q;
        beat_row     = burst_row_q;
        beat_col     = burst_col_q;
        flush        = 1'b0;

        rw_ok    = open_q[ba] && !(burst_q && burst_ap_q && (burst_bank_q == ba));
        new_mask = 3'(bl_q - 4'd1);
        if (cmd == CMD_WRITE && wr_single_q) begin
            new_mask = 3'd0;
        end

        if (cke) begin
            // The beat owned by this edge completes even if BST or PRECHARGE arrives now.
            if (burst_q && !((cmd == CMD_READ || cmd == CMD_WRITE) && rw_ok)) begin
                beat_en     = 1'b1;
                beat_wr     = burst_wr_q;
                beat_col    = burst_column(burst_col_q, burst_cnt_q, burst_mask_q);
                burst_cnt_d = burst_cnt_q + 3'd1;
                if (burst_cnt_q == burst_mask_q) begin
                    burst_d = 1'b0;
                    if (burst_ap_q) begin
                        open_d[burst_bank_q] = 1'b0;
                    end
                end
            end

            case (cmd)
                CMD_LOAD_MODE: begin
                    if (|open_q || burst_q) begin
                        err_d = 1'b1;
                    end
                    bl_d        = bl_decode(a[2:0]);
                    cl_d        = cl_decode(a[6:4]);
                    wr_single_d = a[9];
                end
                CMD_PRECHARGE: begin
                    if (a[10]) begin
                        open_d = '0;
                    end else begin
                        open_d[ba] = 1'b0;
                    end
                    if (burst_q && (a[10] || burst_bank_q == ba)) begin
                        burst_d = 1'b0;
                    end
                end
                CMD_ACTIVE: begin
                    if (open_q[ba]) begin
                        err_d = 1'b1;
                    end else begin
                        open_d[ba] = 1'b1;
                        row_d[ba]  = a;
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (!rw_ok) begin
                        err_d = 1'b1;
                    end else begin
                        if (burst_q && burst_ap_q) begin
                            open_d[burst_bank_q] = 1'b0;
                        end
                        beat_en      = 1'b1;
                        beat_wr      = (cmd == CMD_WRITE);
                        beat_bank    = ba;
                        beat_row     = row_q[ba];
                        beat_col     = a[COL_W-1:0];
                        flush        = (cmd == CMD_WRITE);
                        burst_d      = (new_mask != 3'd0);
                        burst_wr_d   = (cmd == CMD_WRITE);
                        burst_bank_d = ba;
                        burst_row_d  = row_q[ba];
                        burst_col_d  = a[COL_W-1:0];
                        burst_cnt_d  = 3'd1;
                        burst_mask_d = new_mask;
                        burst_ap_d   = a[10];
                        if (new_mask == 3'd0 && a[10]) begin
                            open_d[ba] = 1'b0;
                        end
                    end
                end
                CMD_BST: begin
                    burst_d = 1'b0;
                    if (burst_q && burst_ap_q) begin
                        open_d[burst_bank_q] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_q         <= 4'd1;
            cl_q         <= 2'd2;
            wr_single_q  <= 1'b0;
            open_q       <= '0;
            row_q        <= '{default: '0};
            burst_q      <= 1'b0;
            burst_wr_q   <= 1'b0;
            burst_bank_q <= '0;
            burst_row_q  <= '0;
            burst_col_q  <= '0;
            burst_cnt_q  <= '0;
            burst_mask_q <= '0;
            burst_ap_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            bl_q         <= bl_d;
            cl_q         <= cl_d;
            wr_single_q  <= wr_single_d;
            open_q       <= open_d;
            row_q        <= row_d;
            burst_q      <= burst_d;
            burst_wr_q   <= burst_wr_d;
            burst_bank_q <= burst_bank_d;
            burst_row_q  <= burst_row_d;
            burst_col_q  <= burst_col_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_mask_q <= burst_mask_d;
            burst_ap_q   <= burst_ap_d;
            err_q        <= err_d;
        end
    end

    assign beat_addr = {beat_bank, beat_row, beat_col};
    assign rd_word   = mem_q[beat_addr];

    // NOTE: the storage array has no reset; contents must survive rst_n.
    always_ff @(posedge clk) begin
        if (beat_en && beat_wr) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (!dqm[i]) begin
                    mem_q[beat_addr][8*i +: 8] <= dq[8*i +: 8];
                end
            end
        end
    end

    sdram_rd_pipe #(
        .DQ_W(DQ_W)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cke),
        .flush    (flush),
        .cl       (cl_q),
        .in_valid (beat_en && !beat_wr),
        .in_data  (rd_word),
        .dqm      (dqm),
        .dq_oe    (dq_oe),
        .dq_out   (dq_out)
    );

    for (genvar i = 0; i < DQ_W; i++) begin : g_dq
        assign dq[i] = dq_oe[i] ? dq_out[i] : 1'bz;
    end

    assign err = err_q;

endmodule

// File: doc/sdram_model_param.md
Name: sdram_model_param

Overview:
- Parametrised, cycle-accurate behavioural SDR SDRAM chip model sitting on the SoC SDRAM pins, driven by the SDRAM controller in simulation.
- Generalises the existing 16-bit, 4-bank model in data width, bank count and row/column widths.
- Adds per-bank open-row tracking, a true CAS-latency pipeline, sequential burst wrap, read/write DQM masking, burst terminate, auto-precharge and a sticky protocol-violation flag.

Parameters:
- DQ_W, 16, data width in bits; must be a multiple of 8.
- BANK_W, 2, bank address width; the model has 2^BANK_W banks.
- ROW_W, 13, row address width (a port width).
- COL_W, 9, column address width; must be ≤ 10 because a[10] is the auto-precharge bit.

Ports:
- clk  in  1  model clock; everything is sampled on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cke  in  1  clock enable; low means clock suspend, all state holds.
- cs  in  1  chip select, active-low.
- ras  in  1  row strobe, active-low.
- cas  in  1  column strobe, active-low.
- we  in  1  write enable, active-low.
- a  in  ROW_W  address / mode bus.
- ba  in  BANK_W  bank select.
- dqm  in  DQ_W/8  byte masks; 1 masks the byte.
- dq  inout  DQ_W  data bus; Hi-Z when not driving.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Command decode happens only when cke=1 and cs=0. {ras,cas,we} encodes:
  - 000 LOAD MODE
  - 001 AUTO REFRESH
  - 010 PRECHARGE
  - 011 ACTIVE
  - 100 WRITE
  - 101 READ
  - 110 BURST TERMINATE
  - 111 NOP
- cs=1 is treated as NOP.
- When cke=0, all registers, burst counters and the read pipeline hold, and dq keeps its current drive.
- Reset (asynchronous, rst_n=0):
  - mode register = BL1 / CL2, all banks closed, no burst active, read pipeline cleared.
  - dq is Hi-Z immediately and err=0.
  - Memory contents are not reset.
- Storage: one array of 2^(BANK_W+ROW_W+COL_W) words of DQ_W bits, indexed {bank,row,col}.
- LOAD MODE:
  - a[2:0] selects burst length: 0→1, 1→2, 2→4, 3→8, any other value→1.
  - a[6:4] selects CAS latency: 2→2, any other value→3.
  - a[9]=1 forces single-beat writes.
  - Other bits are ignored.
- ACTIVE: sets open_row[ba]=a and marks bank ba open.
- PRECHARGE: a[10]=1 closes all banks; otherwise closes bank ba. If the closed bank owns the active burst, that burst is terminated.
- AUTO REFRESH: no data effect.
- READ / WRITE:
  - Use open_row[ba] and start column a[COL_W-1:0].
  - Burst addressing is sequential: the low log2(BL) column bits increment modulo BL and the upper column bits stay fixed.
  - A new READ/WRITE truncates any burst in progress.
  - a[10]=1 closes the bank after the last beat.
- WRITE timing:
  - Beat k is sampled from dq at edge T+k, where T is the command edge.
  - Byte i is written only when dqm[i]=0 at that edge.
- READ timing:
  - The word for beat k is fetched at edge T+k and enters a 3-deep data+valid pipeline.
  - dq drives beat k after edge T+k+CL-1, so the controller samples it at edge T+k+CL.
  - dqm has read latency 2: dqm[i]=1 at edge E forces byte i Hi-Z in the cycle after edge E+1.
- BURST TERMINATE: no further beats are fetched or written; beats already in the read pipeline still drain.
- A WRITE issued while read data is in flight flushes the read pipeline, and dq goes Hi-Z from the WRITE edge.
- err is set (sticky until reset) on any of:
  - ACTIVE to an open bank
  - READ/WRITE to a closed bank
  - LOAD MODE while any bank is open or a burst is active
  - READ/WRITE to a bank being auto-precharged
- Violating commands have no effect, except LOAD MODE, which is still applied.

Decomposition:
- Package sdram_model_pkg:
  - command encodings as a 3-bit enum
  - bl_decode and cl_decode functions
  - CL_MAX=3
- Sub-module sdram_rd_pipe:
  - CL-selectable delay line of data+valid plus the 2-stage DQM delay.
  - Outputs the per-bit dq drive enable and dq output data.

Test Plan:
- LOAD MODE a=0x023 (BL8, CL2); ACTIVE ba=1 row=0x10; WRITE col 4 with beats 0x1000..0x1007; READ col 6 → dq from T+2 returns 0x1002,0x1003,0x1004,0x1005,0x1006,0x1007,0x1000,0x1001, then Hi-Z.
- BL1: write 0x1234 to col 0; write 0xABCD with dqm=01; read col 0 → 0xAB34.
- CL3 (a=0x032), BL4, READ then BURST TERMINATE at T+1 → exactly 2 beats driven, at T+3 and T+4; dq Hi-Z from T+5.
- READ to a never-activated bank → err=1 and stays 1; dq stays Hi-Z.
- WRITE BL4 with a[10]=1, then READ to the same bank without ACTIVE → err=1; after a new ACTIVE, the READ returns the written data.
- rst_n pulled low mid-read-burst → dq Hi-Z in the same cycle, err=0, mode BL1/CL2; after ACTIVE, earlier written data reads back intact.
